pipeline_hazard_controller: RTL

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

---
 rtl/pipeline_hazard_controller_pkg.sv | 27 ++
 rtl/pipeline_hazard_controller_forwarding_select.sv | 30 +++
 rtl/pipeline_hazard_controller.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and constants for the pipeline hazard controller: FSM encoding,
// forwarding-select codes and the register-index width.
package pipeline_hazard_controller_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    MUL_WAIT = 2'd2
  } hz_state_t;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_REG = 2'd0;
  localparam fwd_sel_t FWD_EX  = 2'd1;
  localparam fwd_sel_t FWD_MEM = 2'd2;

  // r0 is hard-wired to zero, so it can never be the source of a hazard.
  function automatic logic reg_hit(input reg_idx_t wreg, input reg_idx_t rs,
                                   input reg_idx_t rt);
    return (wreg != '0) && ((wreg == rs) || (wreg == rt));
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_forwarding_select.sv
// Operand forwarding mux select for one ID source register; the nearer
// EX/MEM producer takes priority over MEM/WB.
module forwarding_select
  import pipeline_hazard_controller_pkg::*;
(
  input  reg_idx_t src_reg,
  input  logic     exmem_regwrite,
  input  reg_idx_t exmem_wreg,
  input  logic     memwb_regwrite,
  input  reg_idx_t memwb_wreg,
  output fwd_sel_t fwd_sel
);

  logic ex_match;
  logic mem_match;

  assign ex_match  = exmem_regwrite && (exmem_wreg != '0) && (exmem_wreg == src_reg);
  assign mem_match = memwb_regwrite && (memwb_wreg != '0) && (memwb_wreg == src_reg);

  always_comb begin
    if (ex_match) begin
      fwd_sel = FWD_EX;
    end else if (mem_match) begin
      fwd_sel = FWD_MEM;
    end else begin
      fwd_sel = FWD_REG;
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard unit for a 5-stage pipeline with branch resolution in ID and a
// multi-cycle multiplier: stall/bubble/flush control plus operand forwarding.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  reg_idx_t   id_rs,
  input  reg_idx_t   id_rt,
  input  logic       id_branch,
  input  logic       id_redirect,
  input  logic       id_mul,
  input  logic       idex_memread,
  input  logic       idex_regwrite,
  input  reg_idx_t   idex_wreg,
  input  logic       exmem_memread,
  input  logic       exmem_regwrite,
  input  reg_idx_t   exmem_wreg,
  input  logic       memwb_regwrite,
  input  reg_idx_t   memwb_wreg,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       Ctrl_Mux_Select_Stall,
  output logic       ifid_flush,
  output logic [1:0] Ctrl_FwdA,
  output logic [1:0] Ctrl_FwdB,
  output logic       mul_busy
);

  // MUL_LAT-1 always fits in ceil(log2(MUL_LAT)) bits for MUL_LAT >= 2.
  localparam int CNT_W = $clog2(MUL_LAT);

  hz_state_t        state, state_nx;
  logic [1:0]       stall_cnt, stall_cnt_nx;
  logic [CNT_W-1:0] mul_cnt, mul_cnt_nx;
  logic [1:0]       stall_n;
  logic             hold;
  logic             hit_idex;
  logic             hit_exmem;

  assign hit_idex  = reg_hit(idex_wreg, id_rs, id_rt);
  assign hit_exmem = reg_hit(exmem_wreg, id_rs, id_rt);

  // Terms are applied in ascending order so the last match is the maximum.
  always_comb begin
    stall_n = 2'd0;
    if (!id_branch && idex_memread && hit_idex) begin
      stall_n = 2'd1;
    end
    if (id_branch && exmem_memread && hit_exmem) begin
      stall_n = 2'd1;
    end
    if (id_branch && idex_regwrite && !idex_memread && hit_idex) begin
      stall_n = 2'd1;
    end
    if (id_branch && idex_memread && hit_idex) begin
      stall_n = 2'd2;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RUN;
      stall_cnt <= '0;
      mul_cnt   <= '0;
    end else begin
      state     <= state_nx;
      stall_cnt <= stall_cnt_nx;
      mul_cnt   <= mul_cnt_nx;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_nx     = state;
    stall_cnt_nx = stall_cnt;
    mul_cnt_nx   = mul_cnt;
    hold         = 1'b0;
    ifid_flush   = 1'b0;

    unique case (state)
      RUN: begin
        if (stall_n != 2'd0) begin
          // A hazard beats both a redirect and a new multiply.
          hold = 1'b1;
          if (stall_n == 2'd2) begin
            state_nx     = STALL;
            stall_cnt_nx = 2'd1;
          end
        end else begin
          ifid_flush = id_redirect;
          if (id_mul) begin
            state_nx   = MUL_WAIT;
            mul_cnt_nx = CNT_W'(MUL_LAT - 1);
          end
        end
      end
      STALL: begin
        hold         = 1'b1;
        stall_cnt_nx = stall_cnt - 2'd1;
        if (stall_cnt <= 2'd1) begin
          state_nx     = RUN;
          stall_cnt_nx = 2'd0;
        end
      end
      MUL_WAIT: begin
        hold       = 1'b1;
        mul_cnt_nx = mul_cnt - CNT_W'(1);
        if (mul_cnt <= CNT_W'(1)) begin
          state_nx   = RUN;
          mul_cnt_nx = '0;
        end
      end
      default: begin
        state_nx     = RUN;
        stall_cnt_nx = '0;
        mul_cnt_nx   = '0;
      end
    endcase

    // Outputs show the idle pipeline while reset is held, whatever the inputs.
    if (!reset_n) begin
      hold       = 1'b0;
      ifid_flush = 1'b0;
    end
  end

  assign pc_write              = !hold;
  assign ifid_write            = !hold;
  assign Ctrl_Mux_Select_Stall = !hold;
  assign mul_busy              = (state == MUL_WAIT);

  forwarding_select u_fwd_rs (
    .src_reg        (id_rs),
    .exmem_regwrite (exmem_regwrite),
    .exmem_wreg     (exmem_wreg),
    .memwb_regwrite (memwb_regwrite),
    .memwb_wreg     (memwb_wreg),
    .fwd_sel        (Ctrl_FwdA)
  );

  forwarding_select u_fwd_rt (
    .src_reg        (id_rt),
    .exmem_regwrite (exmem_regwrite),
    .exmem_wreg     (exmem_wreg),
    .memwb_regwrite (memwb_regwrite),
    .memwb_wreg     (memwb_wreg),
    .fwd_sel        (Ctrl_FwdB)
  );

endmodule
